mccu_budget_regulator: RTL
==========================

// Module: mccu_budget_regulator
// PURPOSE
//  Multi-core Maximum-Contention Control Unit with periodic budget replenishment.
//  - Each cycle, subtracts the weighted sum of active contention events from a per-core quota.
//  - Records by how much each quota was overrun.
//  - Raises a sticky per-core interrupt on exhaustion.
//  - Optionally reloads all quotas every period_i cycles (regulation window).
//  - Sits behind the PMU AXI-lite register wrapper; configuration inputs are already registered outside.
// PARAMETERS
//  DATA_WIDTH    32  width of quota and excess registers
//  WEIGHTS_WIDTH 7   width of each event weight
//  N_CORES       4   number of monitored cores (>=1)
//  CORE_EVENTS   4   events per core (>=1)
//  PERIOD_WIDTH  32  width of regulation period counter
// PORTS
//  clk_i          in   1                          clock
//  rstn_i         in   1                          async active-low reset
//  enable_i       in   1                          1: consume quota, count period, allow irq
//  mode_i         in   1                          0: one-shot quota, 1: periodic replenish
//  period_i       in   PERIOD_WIDTH               window length in enabled cycles; 0 disables replenish
//  events_i       in   N_CORES*CORE_EVENTS        core c event e at bit c*CORE_EVENTS+e
//  weights_i      in   N_CORES*CORE_EVENTS*WEIGHTS_WIDTH  weight per event, same index order
//  quota_i        in   N_CORES*DATA_WIDTH         reload/update value per core
//  update_quota_i in   N_CORES                    load quota_i[c] this cycle
//  irq_clear_i    in   N_CORES                    clear sticky irq of core c
//  quota_o        out  N_CORES*DATA_WIDTH         current internal quota
//  excess_o       out  N_CORES*DATA_WIDTH         accumulated overrun since last load
//  exhausted_o    out  N_CORES                    core FSM in EXHAUSTED
//  irq_o          out  N_CORES                    sticky quota interrupt
//  period_tick_o  out  1                          1-cycle pulse at window wrap
// BEHAVIOUR
//  Reset: quota_o, excess_o, ccc_sum, period counter = 0; irq_o = exhausted_o = period_tick_o = 0; FSMs = ACTIVE.
//  Stage 1 (always, regardless of enable):
//   - ccc_sum[c] <= sum over e of (events[c][e] ? weight[c][e] : 0).
//   - SUM_W = WEIGHTS_WIDTH + $clog2(CORE_EVENTS) + 1; ccc_sum never overflows.
//   - Latency: event at cycle n is charged at edge n+2.
//  Period counter: counts only when enable_i & mode_i & period_i != 0.
//   - tick = (cnt == period_i-1) under the same condition; cnt wraps to 0 on tick.
//   - period_tick_o is registered: high in the cycle after the tick edge.
//   - Otherwise cnt holds. Writing period_i below cnt: the counter runs to wrap at 2^PERIOD_WIDTH, then continues normally.
//  Per-core quota update (each edge):
//   - load = update_quota_i[c] | tick.
//   - base = load ? quota_i[c] : quota_int[c].
//   - !enable_i: quota_int <= base; excess <= load ? 0 : excess; FSM <= load ? ACTIVE : unchanged.
//   - enable_i, ccc_sum <= base: quota_int <= base - ccc_sum; excess <= load ? 0 : excess.
//   - enable_i, ccc_sum > base: quota_int <= 0; excess <= (load ? 0 : excess) + (ccc_sum - base).
//   - Excess saturates at all-ones DATA_WIDTH.
//   - Compare in SUM_W/DATA_WIDTH max width, zero-extended; no wrap.
//  Per-core FSM:
//   - ACTIVE -> EXHAUSTED on enable_i & ccc_sum > base.
//   - EXHAUSTED -> ACTIVE on load (a load that itself overruns goes to, or stays in, EXHAUSTED).
//   - ccc_sum == base gives quota 0 and remains ACTIVE.
//  irq_o[c]:
//   - Set on the edge of the ACTIVE->EXHAUSTED transition (visible the cycle after).
//   - Cleared by irq_clear_i[c]; set wins over clear in the same cycle.
//   - Not cleared by tick or update.
//   - Never set while enable_i = 0.
//  Simultaneous update_quota_i and tick: identical load, single reload, no double count.
//  Reset mid-window: everything returns to reset values immediately (async); counter restarts from 0.
// TESTING
//  1 N_CORES=2, weights 3,5,0,1, quota0=20, core0 events 4'b0011 held, enable=1:
//    quota0 20->12->4->0; excess0=4; exhausted0=1; irq0=1 one cycle after reaching 0.
//  2 quota=8, consumption exactly 8 in one cycle:
//    quota 0, excess 0, irq stays 0; next nonzero event -> irq 1.
//  3 mode=1, period=10, quota=50, constant sum 7:
//    period_tick_o every 10 enabled cycles; quota reloads to 50-7=43; excess cleared; irq stays sticky until irq_clear_i.
//  4 irq_clear_i asserted in the same cycle as a new exhaustion:
//    irq_o remains 1; clear with no set -> irq_o 0 next cycle.
//  5 enable_i=0 with events active for 5 cycles:
//    quota unchanged, counter frozen; update_quota_i loads quota_i exactly, no subtraction.
//  6 rstn_i low mid-window, unaligned to clk_i:
//    all outputs 0 immediately; after release, period count restarts, first tick after period_i enabled cycles.

Source files
------------

// File: rtl/mccu_budget_regulator.sv
// Per-core contention budget regulator: charges weighted event sums against a quota,
// tracks overrun, raises sticky interrupts and optionally replenishes quotas each window.
module mccu_budget_regulator #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WEIGHTS_WIDTH = 7,
  parameter int unsigned N_CORES       = 4,
  parameter int unsigned CORE_EVENTS   = 4,
  parameter int unsigned PERIOD_WIDTH  = 32
) (
  input  logic                                       clk_i,
  input  logic                                       rstn_i,
  input  logic                                       enable_i,
  input  logic                                       mode_i,
  input  logic [PERIOD_WIDTH-1:0]                    period_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]             events_i,
  input  logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0] weights_i,
  input  logic [N_CORES*DATA_WIDTH-1:0]              quota_i,
  input  logic [N_CORES-1:0]                         update_quota_i,
  input  logic [N_CORES-1:0]                         irq_clear_i,
  output logic [N_CORES*DATA_WIDTH-1:0]              quota_o,
  output logic [N_CORES*DATA_WIDTH-1:0]              excess_o,
  output logic [N_CORES-1:0]                         exhausted_o,
  output logic [N_CORES-1:0]                         irq_o,
  output logic                                       period_tick_o
);

  localparam int unsigned SUM_W = WEIGHTS_WIDTH + $clog2(CORE_EVENTS) + 1;
  localparam int unsigned CMP_W = (SUM_W > DATA_WIDTH) ? SUM_W : DATA_WIDTH;
  localparam int unsigned ACC_W = CMP_W + 1;

  typedef enum logic [0:0] {StActive, StExhausted} state_e;

  // Regulation window counter
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic [PERIOD_WIDTH-1:0] w_cnt_d;
  logic                    r_tick;
  logic                    w_cnt_en;
  logic                    w_tick;

  assign w_cnt_en = enable_i & mode_i & (period_i != '0);
  assign w_tick   = w_cnt_en & (r_cnt == (period_i - PERIOD_WIDTH'(1)));

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_tick) begin
      w_cnt_d = '0;
    end else if (w_cnt_en) begin
      // A period shrunk below the count simply wraps through 2^PERIOD_WIDTH.
      w_cnt_d = r_cnt + PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_tick <= w_tick;
    end
  end

  assign period_tick_o = r_tick;

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    logic [SUM_W-1:0]      w_sum;
    logic [SUM_W-1:0]      r_ccc_sum;
    logic [DATA_WIDTH-1:0] r_quota;
    logic [DATA_WIDTH-1:0] w_quota_d;
    logic [DATA_WIDTH-1:0] r_excess;
    logic [DATA_WIDTH-1:0] w_excess_d;
    logic [DATA_WIDTH-1:0] w_excess_start;
    logic [DATA_WIDTH-1:0] w_base;
    logic [CMP_W-1:0]      w_base_x;
    logic [CMP_W-1:0]      w_sum_x;
    logic [CMP_W-1:0]      w_rem;
    logic [ACC_W-1:0]      w_acc;
    logic                  w_load;
    logic                  w_over;
    logic                  w_irq_set;
    logic                  r_irq;
    logic                  w_irq_d;
    state_e                r_state;
    state_e                w_state_d;

    always_comb begin
      w_sum = '0;
      for (int unsigned e = 0; e < CORE_EVENTS; e++) begin
        if (events_i[c*CORE_EVENTS+e]) begin
          w_sum = w_sum
                + SUM_W'(weights_i[(c*CORE_EVENTS+e)*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]);
        end
      end
    end

    assign w_load         = update_quota_i[c] | w_tick;
    assign w_base         = w_load ? quota_i[c*DATA_WIDTH +: DATA_WIDTH] : r_quota;
    assign w_excess_start = w_load ? '0 : r_excess;
    assign w_base_x       = CMP_W'(w_base);
    assign w_sum_x        = CMP_W'(r_ccc_sum);
    assign w_over         = w_sum_x > w_base_x;
    assign w_rem          = w_base_x - w_sum_x;
    assign w_acc          = ACC_W'(w_excess_start) + ACC_W'(w_sum_x - w_base_x);
    assign w_irq_set      = enable_i & w_over & (r_state == StActive);

    always_comb begin
      w_quota_d  = w_base;
      w_excess_d = w_excess_start;
      w_state_d  = w_load ? StActive : r_state;
      if (enable_i) begin
        if (w_over) begin
          w_quota_d  = '0;
          w_excess_d = (w_acc > ACC_W'({DATA_WIDTH{1'b1}})) ? '1 : w_acc[DATA_WIDTH-1:0];
          w_state_d  = StExhausted;
        end else begin
          // Sum fits under the base here, so truncating the difference is exact.
          w_quota_d = w_rem[DATA_WIDTH-1:0];
        end
      end
    end

    always_comb begin
      w_irq_d = r_irq;
      if (w_irq_set) begin
        w_irq_d = 1'b1;
      end else if (irq_clear_i[c]) begin
        w_irq_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_state <= StActive;
      end else begin
        r_state <= w_state_d;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_ccc_sum <= '0;
        r_quota   <= '0;
        r_excess  <= '0;
        r_irq     <= 1'b0;
      end else begin
        r_ccc_sum <= w_sum;
        r_quota   <= w_quota_d;
        r_excess  <= w_excess_d;
        r_irq     <= w_irq_d;
      end
    end

    assign quota_o[c*DATA_WIDTH +: DATA_WIDTH]  = r_quota;
    assign excess_o[c*DATA_WIDTH +: DATA_WIDTH] = r_excess;
    assign exhausted_o[c]                       = (r_state == StExhausted);
    assign irq_o[c]                             = r_irq;
  end

endmodule
